ppg_pipe: RTL and testbench

//  Pipelined, parametrised partial-product multiple generator for the MBE radix-8 multiplier.

---
 rtl/ppg_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_ppg_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppg_pipe.sv
// ppg_pipe: pipelined partial-product multiple generator for the MBE radix-8
// multiplier. From one operand X it produces 1X, 2X, 3X and 4X in W = N+3 bits,
// with X zero- or sign-extended according to SIGNED. The 3X carry chain is split
// at bit LO. The low slice is added in stage 1 and the high slice plus carry in
// stage 2. A valid/ready handshake runs through every stage.
//
// Optional feature (macro PPG_NEG_EN): adds the W+1-bit negated multiples
// X_n1x..X_n4x and a third register stage. Latency then becomes 3.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   in_valid   in   1     X is valid this cycle
//   in_ready   out  1     stage 1 can accept this cycle
//   X          in   N+1   operand
//   out_valid  out  1     result multiples valid
//   out_ready  in   1     downstream accepts this cycle
//   X_1x..X_4x out  N+3   1X, 2X, 3X, 4X
//   X_n1x..X_n4x out N+4  negated multiples (PPG_NEG_EN only)
module ppg_pipe #(
   parameter int unsigned N      = 23,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned LO     = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N:0]   X,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N+2:0] X_1x,
   output logic [N+2:0] X_2x,
   output logic [N+2:0] X_3x,
   output logic [N+2:0] X_4x
`ifdef PPG_NEG_EN
   ,
   output logic [N+3:0] X_n1x,
   output logic [N+3:0] X_n2x,
   output logic [N+3:0] X_n3x,
   output logic [N+3:0] X_n4x
`endif
);

   localparam int unsigned W  = N + 3;
   localparam int unsigned HW = W - LO;

   // stage 1 inputs
   logic [W-1:0]  ext_x;
   logic [W-1:0]  x2_d;
   logic [W-1:0]  x4_d;
   logic [LO:0]   lo_sum;

   // stage 1 registers
   logic          s1_valid_q, s1_valid_d;
   logic [W-1:0]  s1_x1_q, s1_x2_q, s1_x4_q;
   logic [LO-1:0] s1_lo_q;
   logic          s1_c_q;

   // 3X assembly from the stage-1 slices
   logic [HW-1:0] hi_sum;
   logic [W-1:0]  x3_d;

   // output registers
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  o1_q, o2_q, o3_q, o4_q;

   // handshake
   logic          out_adv;
   logic          s2_adv;
   logic          accept;

   always_comb begin
      ext_x  = (SIGNED != 0) ? {{2{X[N]}}, X} : {2'b00, X};
      x2_d   = ext_x << 1;
      x4_d   = ext_x << 2;
      lo_sum = {1'b0, ext_x[LO-1:0]} + {1'b0, x2_d[LO-1:0]};
   end

   always_comb begin
      hi_sum = s1_x1_q[W-1:LO] + s1_x2_q[W-1:LO] + HW'(s1_c_q);
      x3_d   = {hi_sum, s1_lo_q};
   end

`ifdef PPG_NEG_EN
   // W+1-bit extension of a W-bit multiple, following the operand signedness
   function automatic logic [W:0] sext(input logic [W-1:0] v);
      return {((SIGNED != 0) && v[W-1]), v};
   endfunction

   logic          s2_valid_q, s2_valid_d;
   logic [W-1:0]  s2_x1_q, s2_x2_q, s2_x3_q, s2_x4_q;
   logic [W:0]    s2_n1_q, s2_n2_q, s2_n4_q;
   logic [W:0]    n1_q, n2_q, n3_q, n4_q;
`endif

   // The stage-2 advance condition is the output advance in the 2-stage build.
   // With the negation stage it also looks through the middle stage.
   always_comb begin
      out_adv     = !out_valid_q || out_ready;
`ifdef PPG_NEG_EN
      s2_adv      = !s2_valid_q || out_adv;
      s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
      out_valid_d = out_adv ? s2_valid_q : out_valid_q;
`else
      s2_adv      = out_adv;
      out_valid_d = out_adv ? s1_valid_q : out_valid_q;
`endif
      in_ready    = !s1_valid_q || s2_adv;
      accept      = in_valid && in_ready;
      s1_valid_d  = accept || (s1_valid_q && !s2_adv);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef PPG_NEG_EN
         s2_valid_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
`ifdef PPG_NEG_EN
         s2_valid_q  <= s2_valid_d;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_x1_q <= '0;
         s1_x2_q <= '0;
         s1_x4_q <= '0;
         s1_lo_q <= '0;
         s1_c_q  <= 1'b0;
      end else if (accept) begin
         s1_x1_q <= ext_x;
         s1_x2_q <= x2_d;
         s1_x4_q <= x4_d;
         s1_lo_q <= lo_sum[LO-1:0];
         s1_c_q  <= lo_sum[LO];
      end
   end

`ifdef PPG_NEG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_x1_q <= '0;
         s2_x2_q <= '0;
         s2_x3_q <= '0;
         s2_x4_q <= '0;
         s2_n1_q <= '0;
         s2_n2_q <= '0;
         s2_n4_q <= '0;
      end else if (s2_adv && s1_valid_q) begin
         s2_x1_q <= s1_x1_q;
         s2_x2_q <= s1_x2_q;
         s2_x3_q <= x3_d;
         s2_x4_q <= s1_x4_q;
         s2_n1_q <= -sext(s1_x1_q);
         s2_n2_q <= -sext(s1_x2_q);
         s2_n4_q <= -sext(s1_x4_q);
      end
   end

   // -3X needs the fully assembled 3X, so it is formed one stage later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o1_q <= '0;
         o2_q <= '0;
         o3_q <= '0;
         o4_q <= '0;
         n1_q <= '0;
         n2_q <= '0;
         n3_q <= '0;
         n4_q <= '0;
      end else if (out_adv && s2_valid_q) begin
         o1_q <= s2_x1_q;
         o2_q <= s2_x2_q;
         o3_q <= s2_x3_q;
         o4_q <= s2_x4_q;
         n1_q <= s2_n1_q;
         n2_q <= s2_n2_q;
         n3_q <= -sext(s2_x3_q);
         n4_q <= s2_n4_q;
      end
   end

   assign X_n1x = n1_q;
   assign X_n2x = n2_q;
   assign X_n3x = n3_q;
   assign X_n4x = n4_q;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o1_q <= '0;
         o2_q <= '0;
         o3_q <= '0;
         o4_q <= '0;
      end else if (s2_adv && s1_valid_q) begin
         o1_q <= s1_x1_q;
         o2_q <= s1_x2_q;
         o3_q <= x3_d;
         o4_q <= s1_x4_q;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign X_1x      = o1_q;
   assign X_2x      = o2_q;
   assign X_3x      = o3_q;
   assign X_4x      = o4_q;

endmodule

// File: tb/tb_ppg_pipe.sv
// Bench for ppg_pipe. Four instances share one stimulus stream:
// unsigned LO=13, unsigned LO=1, unsigned LO=25, and signed LO=13.
// Each accepted operand pushes its expected multiples into a scoreboard.
// A negedge monitor pops and compares every output transfer.
module tb_ppg_pipe;

   localparam int W = 26;
`ifdef PPG_NEG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      logic [W-1:0] u1, u2, u3, u4;
      logic [W-1:0] s1, s2, s3, s4;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [23:0]   x_in = '0;
   logic          ir [4];
   logic          ov [4];
   logic [W-1:0]  o1 [4], o2 [4], o3 [4], o4 [4];
`ifdef PPG_NEG_EN
   logic [W:0]    n1 [4], n2 [4], n3 [4], n4 [4];
`endif

   exp_t sb [$];
   int   rd [4];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   rnd_mode = 1'b0;
   bit   or_fixed = 1'b0;

   always #5 clk = ~clk;

   // out_ready is driven only from here. It follows or_fixed, or is random in rnd_mode.
   always @(posedge clk) begin
      #2 out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : or_fixed;
   end

   for (genvar g = 0; g < 4; g++) begin : g_dut
      ppg_pipe #(
         .N      (23),
         .SIGNED ((g == 3) ? 1 : 0),
         .LO     ((g == 1) ? 1 : ((g == 2) ? 25 : 13))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .X         (x_in),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .X_1x      (o1[g]),
         .X_2x      (o2[g]),
         .X_3x      (o3[g]),
         .X_4x      (o4[g])
`ifdef PPG_NEG_EN
         ,
         .X_n1x     (n1[g]),
         .X_n2x     (n2[g]),
         .X_n3x     (n3[g]),
         .X_n4x     (n4[g])
`endif
      );
   end

   function automatic exp_t mk(input logic [W-1:0] a1, a2, a3, a4, b1, b2, b3, b4);
      exp_t e;
      e.u1 = a1; e.u2 = a2; e.u3 = a3; e.u4 = a4;
      e.s1 = b1; e.s2 = b2; e.s3 = b3; e.s4 = b4;
      return e;
   endfunction

   // Reference multiples by plain multiplication, truncated to W bits
   function automatic exp_t model(input logic [23:0] x);
      exp_t e;
      logic [W-1:0] u, s;
      u = {2'b00, x};
      s = {{2{x[23]}}, x};
      e.u1 = u; e.u2 = u * 26'd2; e.u3 = u * 26'd3; e.u4 = u * 26'd4;
      e.s1 = s; e.s2 = s * 26'd2; e.s3 = s * 26'd3; e.s4 = s * 26'd4;
      return e;
   endfunction

`ifdef PPG_NEG_EN
   function automatic logic [W:0] neg(input logic [W-1:0] v, input bit sg);
      logic [W:0] ext;
      ext = {(sg & v[W-1]), v};
      return 27'd0 - ext;
   endfunction
`endif

   task automatic check_out(input int i);
      exp_t e;
      logic [W-1:0] p1, p2, p3, p4;
      n_chk++;
      if (rd[i] >= sb.size()) begin
         n_fail++;
         $display("FAIL unexpected_out dut%0d got 3x=%h, required no output", i, o3[i]);
         return;
      end
      e = sb[rd[i]];
      rd[i]++;
      p1 = (i == 3) ? e.s1 : e.u1;
      p2 = (i == 3) ? e.s2 : e.u2;
      p3 = (i == 3) ? e.s3 : e.u3;
      p4 = (i == 3) ? e.s4 : e.u4;
      if ({o1[i], o2[i], o3[i], o4[i]} !== {p1, p2, p3, p4}) begin
         n_fail++;
         $display("FAIL multiples dut%0d got %h %h %h %h required %h %h %h %h",
                  i, o1[i], o2[i], o3[i], o4[i], p1, p2, p3, p4);
      end
`ifdef PPG_NEG_EN
      else if ({n1[i], n2[i], n3[i], n4[i]} !==
               {neg(p1, i == 3), neg(p2, i == 3), neg(p3, i == 3), neg(p4, i == 3)}) begin
         n_fail++;
         $display("FAIL negated dut%0d got %h %h %h %h required %h %h %h %h",
                  i, n1[i], n2[i], n3[i], n4[i],
                  neg(p1, i == 3), neg(p2, i == 3), neg(p3, i == 3), neg(p4, i == 3));
      end
`endif
   endtask

   // Monitor: pops on every transfer and checks that stalled outputs hold.
   logic [4*W-1:0] held;
   bit             stall_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (ov[i] && out_ready) check_out(i);
         if (stall_prev && ov[0]) begin
            n_chk++;
            if ({o1[0], o2[0], o3[0], o4[0]} !== held) begin
               n_fail++;
               $display("FAIL stall_hold got %h required %h", {o1[0], o2[0], o3[0], o4[0]}, held);
            end
         end
         stall_prev = ov[0] && !out_ready;
         held       = {o1[0], o2[0], o3[0], o4[0]};
      end
   end

   task automatic send(input logic [23:0] x, input exp_t e);
      int t;
      in_valid = 1'b1;
      x_in     = x;
      t        = 0;
      forever begin
         @(negedge clk);
         if (ir[0]) break;
         t++;
         if (t > 1000) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout x=%h in_ready=%b required 1", x, ir[0]);
            in_valid = 1'b0;
            return;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (rd[0] < sb.size() || rd[1] < sb.size() || rd[2] < sb.size() || rd[3] < sb.size()) begin
         @(posedge clk);
         t++;
         if (t > 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout popped=%0d required=%0d", rd[0], sb.size());
            return;
         end
      end
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   initial begin
      int lat;
      logic [23:0] xr;
      for (int i = 0; i < 4; i++) rd[i] = 0;

      // reset state
      #2;
      chk("reset_out_valid", 128'(ov[0]), 128'd0);
      chk("reset_in_ready", 128'(ir[0]), 128'd1);
      chk("reset_outputs", 128'({o1[0], o2[0], o3[0], o4[0]}), 128'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      or_fixed = 1'b1;
      @(posedge clk);
      #3;

      // all-ones operand plus accept-to-valid latency
      send(24'hFFFFFF, mk(26'h0FFFFFF, 26'h1FFFFFE, 26'h2FFFFFD, 26'h3FFFFFC,
                          26'h3FFFFFF, 26'h3FFFFFE, 26'h3FFFFFD, 26'h3FFFFFC));
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (ov[0]) break;
      end
      chk("latency", 128'(lat), 128'(LAT));
      drain();

      // carry across the LO split, signed minimum, unit operand; back to back
      send(24'h000FFF, mk(26'h0000FFF, 26'h0001FFE, 26'h0002FFD, 26'h0003FFC,
                          26'h0000FFF, 26'h0001FFE, 26'h0002FFD, 26'h0003FFC));
      send(24'h800000, mk(26'h0800000, 26'h1000000, 26'h1800000, 26'h2000000,
                          26'h3800000, 26'h3000000, 26'h2800000, 26'h2000000));
      send(24'h000001, mk(26'h0000001, 26'h0000002, 26'h0000003, 26'h0000004,
                          26'h0000001, 26'h0000002, 26'h0000003, 26'h0000004));
      drain();

      // stall: out_ready low, three back-to-back inputs
      or_fixed = 1'b0;
      @(posedge clk);
      #3;
      send(24'h123456, model(24'h123456));
      send(24'hABCDEF, model(24'hABCDEF));
      in_valid = 1'b1;
      x_in     = 24'h5A5A5A;
      @(negedge clk);
      chk("stall_in_ready", 128'(ir[0]), 128'((LAT == 3) ? 1 : 0));
      if (ir[0]) sb.push_back(model(24'h5A5A5A));
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 or_fixed = 1'b1;
      if (sb.size() == rd[0] + LAT - 1) send(24'h5A5A5A, model(24'h5A5A5A));
      drain();
      chk("stall_count", 128'(rd[0]), 128'(sb.size()));

      // reset with the pipe full
      or_fixed = 1'b0;
      @(posedge clk);
      #3;
      for (int k = 0; k < LAT; k++) send(24'h0F0F0F + 24'(k), model(24'h0F0F0F + 24'(k)));
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 128'(ov[0]), 128'd0);
      chk("midrst_outputs", 128'({o1[0], o2[0], o3[0], o4[0]}), 128'd0);
      chk("midrst_in_ready", 128'(ir[0]), 128'd1);
      for (int i = 0; i < 4; i++) rd[i] = sb.size();
      @(posedge clk);
      #1 rst = 1'b0;
      or_fixed = 1'b1;
      @(posedge clk);
      #3;
      send(24'h000FFF, mk(26'h0000FFF, 26'h0001FFE, 26'h0002FFD, 26'h0003FFC,
                          26'h0000FFF, 26'h0001FFE, 26'h0002FFD, 26'h0003FFC));
      drain();

      // random operands with random gaps and backpressure
      rnd_mode = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         xr = 24'($urandom);
         send(xr, model(xr));
      end
      rnd_mode = 1'b0;
      or_fixed = 1'b1;
      drain();
      for (int i = 0; i < 4; i++) chk("final_count", 128'(rd[i]), 128'(sb.size()));

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1);
   end

endmodule
